// File: rtl/piezo_sched.sv
// Round-robin alert tone scheduler: time-slices one piezo buzzer between NUM_CH level requests.
// Optional silent gap between slots is compiled in with the PIEZO_GAP_EN macro.
module piezo_sched #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned BASE_HALF = 8192,
  parameter int unsigned SLOT_CLKS = 16777216,
  parameter int unsigned GAP_CLKS  = 2097152
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [NUM_CH-1:0]                                req,
  output logic                                             piezo,
  output logic                                             piezo_n,
  output logic                                             busy,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   cur_ch
);

  localparam int unsigned CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TONE_MAX = BASE_HALF << (NUM_CH - 1);
  localparam int unsigned TW       = (TONE_MAX > 1) ? $clog2(TONE_MAX) : 1;
  localparam int unsigned CNT_MAX  = (SLOT_CLKS > GAP_CLKS) ? SLOT_CLKS : GAP_CLKS;
  localparam int unsigned SW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [SW-1:0] SlotLast = SW'(SLOT_CLKS - 1);
`ifdef PIEZO_GAP_EN
  localparam logic [SW-1:0] GapLast  = SW'(GAP_CLKS - 1);
`endif

`ifdef PIEZO_GAP_EN
  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StPlay} state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cur_ch_q, cur_ch_d;
  logic            piezo_q, piezo_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   tone_q, tone_d;
  logic [SW-1:0]   cnt_q, cnt_d;

  logic [CW-1:0]   first_ch;
  logic [CW-1:0]   next_ch;
  logic            next_found;
  logic [TW-1:0]   half_m1;
  logic            slot_end;
  int unsigned     sel_idx;

  // Lowest set request for IDLE exit; rotating scan starting after cur_ch for slot hand-over.
  always_comb begin
    first_ch   = '0;
    next_ch    = cur_ch_q;
    next_found = 1'b0;
    sel_idx    = 0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (req[i]) begin
        first_ch = CW'(i);
      end
    end
    for (int off = int'(NUM_CH); off >= 1; off--) begin
      sel_idx = int'(cur_ch_q) + off;
      if (sel_idx >= NUM_CH) begin
        sel_idx = sel_idx - NUM_CH;
      end
      if (req[CW'(sel_idx)]) begin
        next_ch    = CW'(sel_idx);
        next_found = 1'b1;
      end
    end
  end

  assign half_m1  = TW'((BASE_HALF << cur_ch_q) - 1);
  // Abort and terminal count collapse into one slot end.
  assign slot_end = (cnt_q == SlotLast) || !req[cur_ch_q];

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    piezo_d  = piezo_q;
    tone_d   = tone_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        piezo_d = 1'b0;
        tone_d  = '0;
        cnt_d   = '0;
        if (|req) begin
          state_d  = StPlay;
          cur_ch_d = first_ch;
        end
      end
      StPlay: begin
        if (slot_end) begin
          piezo_d = 1'b0;
          tone_d  = '0;
          cnt_d   = '0;
`ifdef PIEZO_GAP_EN
          state_d = StGap;
`else
          if (next_found) begin
            cur_ch_d = next_ch;
          end else begin
            state_d = StIdle;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (tone_q == half_m1) begin
            piezo_d = ~piezo_q;
            tone_d  = '0;
          end else begin
            tone_d = tone_q + 1'b1;
          end
        end
      end
`ifdef PIEZO_GAP_EN
      StGap: begin
        piezo_d = 1'b0;
        tone_d  = '0;
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (next_found) begin
            state_d  = StPlay;
            cur_ch_d = next_ch;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        piezo_d = 1'b0;
        tone_d  = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cur_ch_q <= '0;
      piezo_q  <= 1'b0;
      busy_q   <= 1'b0;
      tone_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      piezo_q  <= piezo_d;
      busy_q   <= busy_d;
      tone_q   <= tone_d;
      cnt_q    <= cnt_d;
    end
  end

  assign piezo   = piezo_q;
  assign piezo_n = ~piezo_q;
  assign busy    = busy_q;
  assign cur_ch  = cur_ch_q;

endmodule

// File: tb/tb_piezo_sched.sv
// Self-checking bench for piezo_sched: directed vector table, corner-case sequences and
// randomized requests compared cycle by cycle against a slot/age reference model.
module tb_piezo_sched;

  localparam int unsigned N    = 3;
  localparam int unsigned BH   = 4;
  localparam int unsigned SLOT = 32;
  localparam int unsigned GAP  = 8;
`ifdef PIEZO_GAP_EN
  localparam int L = GAP;
`else
  localparam int L = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic       piezo, piezo_n, busy;
  logic [1:0] cur_ch;

  piezo_sched #(
    .NUM_CH   (N),
    .BASE_HALF(BH),
    .SLOT_CLKS(SLOT),
    .GAP_CLKS (GAP)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .piezo  (piezo),
    .piezo_n(piezo_n),
    .busy   (busy),
    .cur_ch (cur_ch)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0 idle, 1 playing, 2 gap; age = cycles since mode entry.
  int m_mode = 0;
  int m_ch   = 0;
  int m_age  = 0;

  typedef struct {
    logic [2:0] req;
    int         cycles;
    logic       p;
    logic       b;
    logic [1:0] ch;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit req_bit(input logic [2:0] r, input int c);
    return ((r >> c) & 3'd1) != 3'd0;
  endfunction

  function automatic int pick_after(input int from, input logic [2:0] r);
    for (int k = 1; k <= int'(N); k++) begin
      int c;
      c = (from + k) % int'(N);
      if (req_bit(r, c)) return c;
    end
    return -1;
  endfunction

  task automatic model_select(input logic [2:0] r);
    int c;
    c = pick_after(m_ch, r);
    if (c < 0) begin
      m_mode = 0;
    end else begin
      m_mode = 1;
      m_ch   = c;
      m_age  = 0;
    end
  endtask

  task automatic model_step(input logic [2:0] r);
    case (m_mode)
      0: if (r != 3'b000) begin
        m_mode = 1;
        m_ch   = pick_after(int'(N) - 1, r);
        m_age  = 0;
      end
      1: if (m_age == int'(SLOT) - 1 || !req_bit(r, m_ch)) begin
`ifdef PIEZO_GAP_EN
        m_mode = 2;
        m_age  = 0;
`else
        model_select(r);
`endif
      end else begin
        m_age++;
      end
      default: if (m_age == int'(GAP) - 1) model_select(r); else m_age++;
    endcase
  endtask

  task automatic compare_model();
    logic exp_p;
    logic exp_b;
    exp_p = (m_mode == 1) && (((m_age / int'(BH << m_ch)) % 2) == 1);
    exp_b = (m_mode != 0);
    check("model", {3'b0, piezo, piezo_n, busy, cur_ch}, {3'b0, exp_p, ~exp_p, exp_b, 2'(m_ch)});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(req);
    @(negedge clk);
    compare_model();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check("reset_async", {3'b0, piezo, piezo_n, busy, cur_ch}, 8'b000_0_1_0_00);
    m_mode = 0;
    m_ch   = 0;
    m_age  = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hold;

    tbl[0] = '{3'b000, 3,  1'b0, 1'b0, 2'd0};
    tbl[1] = '{3'b001, 1,  1'b0, 1'b1, 2'd0};
    tbl[2] = '{3'b001, 4,  1'b1, 1'b1, 2'd0};
    tbl[3] = '{3'b001, 3,  1'b1, 1'b1, 2'd0};
    tbl[4] = '{3'b001, 1,  1'b0, 1'b1, 2'd0};
    tbl[5] = '{3'b001, 20, 1'b1, 1'b1, 2'd0};
    tbl[6] = '{3'b001, 3,  1'b1, 1'b1, 2'd0};
    tbl[7] = '{3'b001, 1,  1'b0, 1'b1, 2'd0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table: single channel through one full slot.
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req;
      ticks(tbl[i].cycles);
      check($sformatf("tbl%0d", i), {5'b0, piezo, busy, cur_ch},
            {5'b0, tbl[i].p, tbl[i].b, tbl[i].ch});
    end

    // Reset in the middle of a channel 2 slot.
    do_reset();
    req = 3'b100;
    ticks(20);
    check("pre_rst", {5'b0, piezo, busy, cur_ch}, {5'b0, 1'b1, 1'b1, 2'd2});
    do_reset();
    req = 3'b000;
    ticks(3);
    check("post_rst", {3'b0, piezo, piezo_n, busy, cur_ch}, 8'b000_0_1_0_00);

    // Two-channel rotation: ch0, ch2 (high only on cycles 16-31), ch0.
    req = 3'b101;
    ticks(1);
    check("rot2_ch0", {6'b0, cur_ch}, 8'd0);
    ticks(31);
    ticks(L + 1);
    check("rot2_ch2", {5'b0, piezo, busy, cur_ch}, {5'b0, 1'b0, 1'b1, 2'd2});
    for (int t = 1; t < 32; t++) begin
      tick();
      check($sformatf("ch2_wave%0d", t), {7'b0, piezo}, {7'b0, (t >= 16)});
    end
    ticks(L + 1);
    check("rot2_back", {5'b0, piezo, busy, cur_ch}, {5'b0, 1'b0, 1'b1, 2'd0});

    // Abort of channel 1 at PLAY cycle 10.
    do_reset();
    req = 3'b010;
    ticks(11);
    check("abort_pre", {5'b0, piezo, busy, cur_ch}, {5'b0, 1'b1, 1'b1, 2'd1});
    req = 3'b000;
    tick();
`ifdef PIEZO_GAP_EN
    check("abort_gap", {5'b0, piezo, busy, cur_ch}, {5'b0, 1'b0, 1'b1, 2'd1});
    ticks(int'(GAP) - 1);
    check("abort_gap_end", {7'b0, busy}, 8'd1);
    tick();
`endif
    check("abort_idle", {5'b0, piezo, busy, cur_ch}, {5'b0, 1'b0, 1'b0, 2'd1});

    // Late request: ch2 raised at ch0 cycle 5 waits for the slot to finish.
    do_reset();
    req = 3'b001;
    ticks(6);
    req = 3'b101;
    ticks(26);
    check("late_ch0_end", {5'b0, piezo, busy, cur_ch}, {5'b0, 1'b1, 1'b1, 2'd0});
    ticks(L + 1);
    check("late_ch2", {5'b0, piezo, busy, cur_ch}, {5'b0, 1'b0, 1'b1, 2'd2});
    ticks(32 + L);
    check("late_ch0_again", {5'b0, piezo, busy, cur_ch}, {5'b0, 1'b0, 1'b1, 2'd0});

    // Full rotation 0,1,2,0.
    do_reset();
    req = 3'b111;
    ticks(1);
    check("full_rot0", {6'b0, cur_ch}, 8'd0);
    for (int s = 1; s <= 3; s++) begin
      ticks(32 + L);
      check($sformatf("full_rot%0d", s), {5'b0, piezo, busy, cur_ch},
            {5'b0, 1'b0, 1'b1, 2'(s % 3)});
    end

    // Randomized requests with occasional asynchronous reset.
    do_reset();
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        req  = 3'($urandom_range(0, 7));
        hold = int'($urandom_range(1, 90));
      end
      hold--;
      if ($urandom_range(0, 999) == 0) do_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
